// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access encodings, FSM states
// and the default access timeout.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, replicated store data, load
// extraction with sign/zero extension, and misaligned/illegal detection.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    always_comb begin
        byte_en    = 4'b0000;
        wdata      = store_data;
        load_data  = read_word;
        misaligned = 1'b0;
        illegal    = 1'b0;
        // Bring the addressed byte/halfword down to bit 0 before extending.
        shifted    = read_word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
                illegal   = is_store & funct3[2];
            end
            F3_H, F3_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = funct3[2] ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
                illegal    = is_store & funct3[2];
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata      = store_data;
                load_data  = read_word;
                misaligned = |addr_lo;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: issues data-memory requests over req/ack, stalls while waiting,
// aborts on timeout, and owns the MEM/WB pipeline register.
module memory_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_result,
    input  logic [31:0] data2,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        memory_read_enable,
    input  logic        memory_write_enable,
    input  logic        regwrite_enable,
    input  logic        mux3_select,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] MEM_WB_read_data,
    output logic [31:0] MEM_WB_ALU_result,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regWrite,
    output logic        MEM_WB_memRead,
    output logic        MEM_WB_mux3_select,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mem_op, rw_conflict, access_fault, decode_fault;
    logic             misaligned, illegal;
    logic [31:0]      load_data;
    logic             retire_now, timeout_hit, fault_now;

    load_store_align u_align (
        .addr_lo    (ALU_result[1:0]),
        .store_data (data2),
        .funct3     (funct3),
        .is_store   (memory_write_enable),
        .read_word  (mem_rdata),
        .byte_en    (mem_byte_en),
        .wdata      (mem_wdata),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign mem_op       = memory_read_enable ^ memory_write_enable;
    assign rw_conflict  = memory_read_enable & memory_write_enable;
    assign access_fault = mem_op & (misaligned | illegal);
    assign decode_fault = rw_conflict | access_fault;

    // Handshake: mem_req stays high with stable fields until the cycle mem_ack
    // is seen (possibly the first); stall holds upstream until then.
    assign mem_req  = mem_op & ~access_fault & ((state == IDLE) || (state == WAIT)) & ~reset;
    assign stall    = mem_req & ~mem_ack;
    assign mem_we   = memory_write_enable;
    assign mem_addr = {ALU_result[31:2], 2'b00};

    always_comb begin
        retire_now  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    retire_now  = ~decode_fault & ~stall;
            WAIT: begin
                retire_now  = mem_req & mem_ack;
                timeout_hit = stall & (cnt == TIMEOUT_LIMIT);
            end
            default: retire_now = 1'b0;
        endcase
        fault_now = ((state == IDLE) & decode_fault) | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!stall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (timeout_hit) begin
                        state <= ABORT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Anything that does not retire writes a bubble: no rd, no writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            MEM_WB_read_data   <= '0;
            MEM_WB_ALU_result  <= '0;
            MEM_WB_rd          <= '0;
            MEM_WB_regWrite    <= 1'b0;
            MEM_WB_memRead     <= 1'b0;
            MEM_WB_mux3_select <= 1'b0;
            fault              <= 1'b0;
            fault_addr         <= '0;
        end else begin
            fault <= fault_now;
            if (fault_now) begin
                fault_addr <= ALU_result;
            end
            if (retire_now) begin
                MEM_WB_read_data   <= memory_read_enable ? load_data : 32'h0;
                MEM_WB_ALU_result  <= ALU_result;
                MEM_WB_rd          <= rd;
                MEM_WB_regWrite    <= regwrite_enable;
                MEM_WB_memRead     <= memory_read_enable;
                MEM_WB_mux3_select <= mux3_select;
            end else begin
                MEM_WB_rd       <= '0;
                MEM_WB_regWrite <= 1'b0;
                MEM_WB_memRead  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: vector table for single-cycle accesses plus
// hand sequences for wait states, timeout/abort and reset during a wait.
module tb_memory_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALU_result, data2, mem_rdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        memory_read_enable, memory_write_enable, regwrite_enable, mux3_select;
    logic        mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_req, mem_we, stall;
    logic [31:0] MEM_WB_read_data, MEM_WB_ALU_result;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regWrite, MEM_WB_memRead, MEM_WB_mux3_select;
    logic        fault;
    logic [31:0] fault_addr;

    memory_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .ALU_result         (ALU_result),
        .data2              (data2),
        .funct3             (funct3),
        .rd                 (rd),
        .memory_read_enable (memory_read_enable),
        .memory_write_enable(memory_write_enable),
        .regwrite_enable    (regwrite_enable),
        .mux3_select        (mux3_select),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_byte_en        (mem_byte_en),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .stall              (stall),
        .MEM_WB_read_data   (MEM_WB_read_data),
        .MEM_WB_ALU_result  (MEM_WB_ALU_result),
        .MEM_WB_rd          (MEM_WB_rd),
        .MEM_WB_regWrite    (MEM_WB_regWrite),
        .MEM_WB_memRead     (MEM_WB_memRead),
        .MEM_WB_mux3_select (MEM_WB_mux3_select),
        .fault              (fault),
        .fault_addr         (fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bubble;
        logic [31:0] read_data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        regw;
        logic        memr;
        logic        mux;
        logic        flt;
        logic [31:0] faddr;
    } wb_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] d2;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rde;
        logic        wre;
        logic        rwe;
        logic [31:0] rdata;
        logic        req;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdx;
        logic        flt;
    } vec_t;

    localparam int NV = 17;
    vec_t        vecs[NV];
    wb_t         exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_faddr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] alu, input logic [31:0] d2, input logic [2:0] f3,
                         input logic [4:0] rd_i, input logic rde, input logic wre, input logic rwe,
                         input logic [31:0] rdata, input logic ack);
        ALU_result          = alu;
        data2               = d2;
        funct3              = f3;
        rd                  = rd_i;
        memory_read_enable  = rde;
        memory_write_enable = wre;
        regwrite_enable     = rwe;
        mux3_select         = 1'($urandom_range(0, 1));
        mem_rdata           = rdata;
        mem_ack             = ack;
    endtask

    task automatic check_comb(input string tag, input logic req, input logic stl,
                              input logic [3:0] be, input logic [31:0] wd, input logic chk_wd);
        check({tag, "_req"}, 32'(mem_req), 32'(req));
        check({tag, "_stall"}, 32'(stall), 32'(stl));
        if (req) begin
            check({tag, "_be"}, 32'(mem_byte_en), 32'(be));
            check({tag, "_addr"}, mem_addr, {ALU_result[31:2], 2'b00});
            check({tag, "_we"}, 32'(mem_we), 32'(memory_write_enable));
            if (chk_wd) check({tag, "_wdata"}, mem_wdata, wd);
        end
    endtask

    task automatic push_retire(input logic [31:0] rdx);
        wb_t e;
        e.bubble    = 1'b0;
        e.read_data = rdx;
        e.alu       = ALU_result;
        e.rd        = rd;
        e.regw      = regwrite_enable;
        e.memr      = memory_read_enable;
        e.mux       = mux3_select;
        e.flt       = 1'b0;
        e.faddr     = exp_faddr;
        exp_q.push_back(e);
    endtask

    task automatic push_bubble(input logic flt);
        wb_t e;
        if (flt) exp_faddr = ALU_result;
        e        = '0;
        e.bubble = 1'b1;
        e.flt    = flt;
        e.faddr  = exp_faddr;
        exp_q.push_back(e);
    endtask

    task automatic push_zero();
        exp_faddr = 32'h0;
        exp_q.push_back('0);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_wb_rd"}, 32'(MEM_WB_rd), 32'(e.rd));
            check({tag, "_wb_regw"}, 32'(MEM_WB_regWrite), 32'(e.regw));
            check({tag, "_wb_memr"}, 32'(MEM_WB_memRead), 32'(e.memr));
            check({tag, "_fault"}, 32'(fault), 32'(e.flt));
            check({tag, "_faddr"}, fault_addr, e.faddr);
            if (!e.bubble) begin
                check({tag, "_wb_data"}, MEM_WB_read_data, e.read_data);
                check({tag, "_wb_alu"}, MEM_WB_ALU_result, e.alu);
                check({tag, "_wb_mux"}, 32'(MEM_WB_mux3_select), 32'(e.mux));
            end
        end
    endtask

    task automatic slow_load(input string tag, input logic [2:0] f3, input logic [4:0] rd_i,
                             input logic [31:0] rdx);
        apply(32'h0000_2001, 32'h0, f3, rd_i, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #2;
            check_comb($sformatf("%s_w%0d", tag, c), 1'b1, 1'b1, 4'b0010, 32'h0, 1'b0);
            push_bubble(1'b0);
            tick();
            check_wb($sformatf("%s_w%0d", tag, c));
        end
        mem_rdata = 32'h0000_8000;
        mem_ack   = 1'b1;
        #2;
        check_comb({tag, "_ack"}, 1'b1, 1'b0, 4'b0010, 32'h0, 1'b0);
        push_retire(rdx);
        tick();
        check_wb({tag, "_ack"});
    endtask

    task automatic timeout_seq(input string tag, input logic [31:0] addr, input logic [4:0] rd_i);
        apply(addr, 32'h0, 3'b010, rd_i, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int c = 0; c <= TO; c++) begin
            #2;
            check_comb($sformatf("%s_s%0d", tag, c), 1'b1, 1'b1, 4'b1111, 32'h0, 1'b0);
            push_bubble(c == TO);
            tick();
            check_wb($sformatf("%s_s%0d", tag, c));
        end
        // Late ack during the abort cycle must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        #2;
        check_comb({tag, "_abort"}, 1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
        push_bubble(1'b0);
        tick();
        check_wb({tag, "_abort"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_1234, 32'h0,         3'b000, 5'd5,  1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{32'h0000_1003, 32'h0000_00AB, 3'b000, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0,         1'b0};
        vecs[2]  = '{32'h0000_1002, 32'h1234_BEEF, 3'b001, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0};
        vecs[3]  = '{32'h0000_1000, 32'hDEAD_BEEF, 3'b010, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4]  = '{32'h0000_2002, 32'h0,         3'b001, 5'd7,  1'b1, 1'b0, 1'b1, 32'h8001_0000, 1'b1, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0};
        vecs[5]  = '{32'h0000_2002, 32'h0,         3'b101, 5'd8,  1'b1, 1'b0, 1'b1, 32'h8001_0000, 1'b1, 4'b1100, 32'h0,         32'h0000_8001, 1'b0};
        vecs[6]  = '{32'h0000_2004, 32'h0,         3'b010, 5'd9,  1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[7]  = '{32'h0000_2000, 32'h0,         3'b000, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 4'b0001, 32'h0,         32'h0000_007F, 1'b0};
        vecs[8]  = '{32'h0000_2003, 32'h0,         3'b100, 5'd11, 1'b1, 1'b0, 1'b1, 32'h9A00_0000, 1'b1, 4'b1000, 32'h0,         32'h0000_009A, 1'b0};
        vecs[9]  = '{32'h0000_1001, 32'h1234_56C3, 3'b000, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 4'b0010, 32'hC3C3_C3C3, 32'h0,         1'b0};
        vecs[10] = '{32'h0000_2002, 32'h0,         3'b010, 5'd12, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{32'h0000_2001, 32'h0,         3'b001, 5'd13, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{32'h0000_1001, 32'h1111_2222, 3'b010, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[13] = '{32'h0000_2000, 32'h0,         3'b011, 5'd14, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[14] = '{32'h0000_1000, 32'h0,         3'b100, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[15] = '{32'h0000_3000, 32'h0,         3'b010, 5'd15, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1};
        vecs[16] = '{32'hFFFF_FFFF, 32'h0,         3'b000, 5'd31, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b0};

        // Reset with a valid load presented: no request, everything cleared.
        reset = 1'b1;
        apply(32'h0000_2000, 32'h0, 3'b010, 5'd3, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        check_comb("reset", 1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
        push_zero();
        tick();
        check_wb("reset");
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].alu, vecs[i].d2, vecs[i].f3, vecs[i].rd, vecs[i].rde, vecs[i].wre,
                  vecs[i].rwe, vecs[i].rdata, vecs[i].req);
            #2;
            check_comb($sformatf("vec%0d", i), vecs[i].req, 1'b0, vecs[i].be, vecs[i].wd, vecs[i].wre);
            if (vecs[i].flt) push_bubble(1'b1);
            else             push_retire(vecs[i].rdx);
            tick();
            check_wb($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            apply($urandom, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'b0, 1'b0,
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            #2;
            check_comb($sformatf("alu%0d", i), 1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
            push_retire(32'h0);
            tick();
            check_wb($sformatf("alu%0d", i));
        end

        slow_load("lb_wait", 3'b000, 5'd20, 32'hFFFF_FF80);
        slow_load("lbu_wait", 3'b100, 5'd21, 32'h0000_0080);

        timeout_seq("tmo", 32'h0000_2008, 5'd22);

        apply(32'h0000_ABCD, 32'h0, 3'b000, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        #2;
        check_comb("post_abort_alu", 1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
        push_retire(32'h0);
        tick();
        check_wb("post_abort_alu");

        apply(32'h0000_200C, 32'h0, 3'b010, 5'd4, 1'b1, 1'b0, 1'b1, 32'h1122_3344, 1'b1);
        #2;
        check_comb("post_abort_lw", 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0);
        push_retire(32'h1122_3344);
        tick();
        check_wb("post_abort_lw");

        // Reset in the second WAIT cycle.
        apply(32'h0000_2010, 32'h0, 3'b010, 5'd13, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #2;
            check_comb($sformatf("rst_wait%0d", c), 1'b1, 1'b1, 4'b1111, 32'h0, 1'b0);
            push_bubble(1'b0);
            tick();
            check_wb($sformatf("rst_wait%0d", c));
        end
        reset = 1'b1;
        #2;
        check_comb("rst_mid", 1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
        push_zero();
        tick();
        check_wb("rst_mid");
        reset = 1'b0;

        // A full-length timeout after reset shows the counter restarted from IDLE.
        timeout_seq("tmo_after_rst", 32'h0000_2014, 5'd23);

        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
